dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the single-cycle core.
// Serves word loads/stores against a small data RAM and a memory-mapped I/O
// window holding a free-running cycle counter and a transmit FIFO. The FIFO
// drains to an external consumer over a valid/ready port.
module dmem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0004;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0008;

  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  // Which target the current access selects.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_TXDATA,
    SEL_STATUS
  } sel_e;

  sel_e             sel;
  logic [31:0]      word_addr;
  logic [AW-1:0]    ram_idx;

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      cycle_cnt;

  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             overflow;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             fifo_wr_en;
  logic             ovf_set;
  logic             ovf_clr;
  logic [31:0]      status_word;

  // Byte-lane bits are irrelevant for word-only accesses.
  logic             unused_byte_lane;
  assign unused_byte_lane = ^ALUResult[1:0];

  assign word_addr = {ALUResult[31:2], 2'b00};
  assign ram_idx   = ALUResult[AW+1:2];

  // Address decode: RAM sits at the bottom of the low half; I/O registers
  // are exact word matches in the high half. Everything else is a hole.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no input
    // combination can leave it holding a value (which would infer a latch).
    sel = SEL_NONE;
    if (!ALUResult[31]) begin
      if (ALUResult[30:AW+2] == '0) sel = SEL_RAM;
    end else begin
      case (word_addr)
        ADDR_CYCLE:  sel = SEL_CYCLE;
        ADDR_TXDATA: sel = SEL_TXDATA;
        ADDR_STATUS: sel = SEL_STATUS;
        default:     sel = SEL_NONE;
      endcase
    end
  end

  // FIFO handshake and status flags.
  assign fifo_full  = (count == COUNT_FULL);
  assign fifo_empty = (count == '0);
  assign tx_valid   = !fifo_empty;
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : '0;

  assign push = MemWrite && (sel == SEL_TXDATA);
  assign pop  = tx_valid && tx_ready;

  // A push into a full FIFO still lands when a pop frees the head slot.
  assign fifo_wr_en = push && !reset && (pop || !fifo_full);
  assign ovf_set    = push && !pop && fifo_full;
  assign ovf_clr    = MemWrite && (sel == SEL_STATUS) && WriteData[2];

  assign status_word = {16'h0000, 8'(count), 5'b00000, overflow, fifo_empty, fifo_full};

  // Load data mux; combinational so the core completes loads in one cycle.
  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:    ReadData = ram[ram_idx];
      SEL_CYCLE:  ReadData = cycle_cnt;
      SEL_STATUS: ReadData = status_word;
      default:    ReadData = '0;
    endcase
  end

  // Free-running cycle counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop in
    // the design samples pre-edge values, independent of block ordering.
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Storage arrays: data RAM and FIFO slots.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are intentionally left out of reset; contents
    // persist across reset and only the pointers/count define validity.
    if (MemWrite && (sel == SEL_RAM)) ram[ram_idx] <= WriteData;
    if (fifo_wr_en)                   fifo_mem[wr_ptr] <= WriteData;
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        wr_ptr <= wr_ptr + PW'(1);
      end else if (push) begin
        if (!fifo_full) begin
          wr_ptr <= wr_ptr + PW'(1);
          count  <= count + CW'(1);
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        count  <= count - CW'(1);
      end
    end
  end

  // Sticky overflow flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (counter, overflow,
// full push+pop, reset mid-operation).
module tb_dmem_responder;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_TXDATA = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic [31:0] exp_txd;
  } vec_t;

  vec_t vecs[$];

  dmem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs for the coming cycle (called right after a falling edge).
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ready);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wdata;
    tx_ready  = ready;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Combinational read check within the current low phase.
  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    ALUResult = addr;
    #1;
    check(name, ReadData, exp);
  endtask

  task automatic push_word(input logic [31:0] data);
    @(negedge clk);
    drive(1'b1, A_TXDATA, data, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // ---------------- reset and cycle counter ----------------
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_tx_data", tx_data, 32'h0);
    rd_check("reset_status", A_STATUS, 32'h0000_0002);
    rd_check("cycle_first", A_CYCLE, 32'h0);
    repeat (5) @(negedge clk);
    rd_check("cycle_after5", A_CYCLE, 32'd5);
    rd_check("cycle_addr_lanes", A_CYCLE | 32'h3, 32'd5);

    // Write to CYCLE is ignored.
    @(negedge clk);
    drive(1'b1, A_CYCLE, 32'h1234_0000, 1'b0);
    @(negedge clk);
    idle();
    rd_check("cycle_write_ignored", A_CYCLE, 32'd7);

    // Counter wrap from all ones.
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    rd_check("cycle_forced", A_CYCLE, 32'hFFFF_FFFF);
    @(negedge clk);
    rd_check("cycle_wrap", A_CYCLE, 32'h0);

    // ---------------- table-driven vectors ----------------
    //            name              we    addr          wdata         rdy   chk   exp_rd        vld   txd
    vecs.push_back('{"ram_wr_10",   1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{"ram_wr_14",   1'b1, 32'h14,       32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{"ram_rd_10",   1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{"ram_rd_13",   1'b0, 32'h13,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{"ram_rd_14",   1'b0, 32'h14,       32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0});
    vecs.push_back('{"hole_rd_4e",  1'b0, 32'h4000_0000,32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{"hole_rd_100", 1'b0, 32'h100,      32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{"hole_wr_110", 1'b1, 32'h110,      32'h11111111, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{"ram_no_alias",1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{"push_a",      1'b1, A_TXDATA,     32'hA,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0});
    vecs.push_back('{"push_b",      1'b1, A_TXDATA,     32'hB,        1'b0, 1'b1, 32'h0,        1'b1, 32'hA});
    vecs.push_back('{"push_c",      1'b1, A_TXDATA,     32'hC,        1'b0, 1'b1, 32'h0,        1'b1, 32'hA});
    vecs.push_back('{"status_3",    1'b0, A_STATUS,     32'h0,        1'b0, 1'b1, 32'h0000_0300,1'b1, 32'hA});
    vecs.push_back('{"txdata_rd",   1'b0, A_TXDATA,     32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 32'hA});
    vecs.push_back('{"drain_a",     1'b0, A_STATUS,     32'h0,        1'b1, 1'b1, 32'h0000_0300,1'b1, 32'hA});
    vecs.push_back('{"drain_b",     1'b0, A_STATUS,     32'h0,        1'b1, 1'b1, 32'h0000_0200,1'b1, 32'hB});
    vecs.push_back('{"drain_c",     1'b0, A_STATUS,     32'h0,        1'b1, 1'b1, 32'h0000_0100,1'b1, 32'hC});
    vecs.push_back('{"drained",     1'b0, A_STATUS,     32'h0,        1'b1, 1'b1, 32'h0000_0002,1'b0, 32'h0});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
      #1;
      if (vecs[i].chk_rd) check({vecs[i].name, "_rd"}, ReadData, vecs[i].exp_rd);
      check({vecs[i].name, "_valid"}, {31'b0, tx_valid}, {31'b0, vecs[i].exp_valid});
      check({vecs[i].name, "_txd"}, tx_data, vecs[i].exp_txd);
    end
    @(negedge clk);
    idle();

    // ---------------- overflow ----------------
    for (int i = 0; i < 9; i++) push_word(32'h100 + i);
    @(negedge clk);
    idle();
    rd_check("ovf_status", A_STATUS, 32'h0000_0805);
    @(negedge clk);
    drive(1'b1, A_STATUS, 32'h4, 1'b0);
    #1;
    check("ovf_clear_pre_edge", ReadData, 32'h0000_0805);
    @(negedge clk);
    idle();
    rd_check("ovf_cleared", A_STATUS, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      check($sformatf("ovf_drain_%0d", i), tx_data, 32'h100 + i);
    end
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    check("ovf_ninth_dropped", {31'b0, tx_valid}, 32'h0);
    rd_check("ovf_empty_status", A_STATUS, 32'h0000_0002);

    // ---------------- full with simultaneous push and pop ----------------
    for (int i = 0; i < 8; i++) push_word(32'h200 + i);
    @(negedge clk);
    idle();
    rd_check("full_status", A_STATUS, 32'h0000_0801);
    @(negedge clk);
    drive(1'b1, A_TXDATA, 32'h55, 1'b1);
    #1;
    check("full_pp_head", tx_data, 32'h200);
    @(negedge clk);
    idle();
    rd_check("full_pp_status", A_STATUS, 32'h0000_0801);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      check($sformatf("full_pp_drain_%0d", i), tx_data, (i < 7) ? (32'h201 + i) : 32'h55);
    end
    @(negedge clk);
    tx_ready = 1'b0;
    rd_check("full_pp_empty", A_STATUS, 32'h0000_0002);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 3; i++) push_word(32'h31 + i);
    @(negedge clk);
    idle();
    rd_check("mid_status", A_STATUS, 32'h0000_0300);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, A_TXDATA, 32'h99, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
    check("mid_rst_txd", tx_data, 32'h0);
    rd_check("mid_rst_status", A_STATUS, 32'h0000_0002);
    rd_check("mid_rst_cycle", A_CYCLE, 32'h0);
    rd_check("mid_rst_ram", 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    rd_check("mid_rst_cycle1", A_CYCLE, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
